// File: rtl/run_window_scan_scheduler.sv
// Sliding-window scan scheduler: copies each LxL window of the frame integral
// image into the classifier RAM, runs the classifier and reports detections.
module run_window_scan_scheduler #(
  parameter int unsigned LENGHT_LINE_II = 21,
  parameter int unsigned IMG_W          = 64,
  parameter int unsigned IMG_H          = 48,
  parameter int unsigned STEP           = 1,
  parameter int unsigned ADDR_WIDTH_II  = $clog2(LENGHT_LINE_II*LENGHT_LINE_II),
  parameter int unsigned ADDR_WIDTH_FR  = $clog2(IMG_W*IMG_H),
  parameter int unsigned COORD_W        = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     frame_start_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     fr_rd_o,
  output logic [ADDR_WIDTH_FR-1:0] fr_addr_o,
  input  logic [31:0]              fr_data_i,
  input  logic                     vnf_val_i,
  input  logic [31:0]              vnf_i,
  output logic [ADDR_WIDTH_II-1:0] ii_addr_wr_o,
  output logic [31:0]              ii_data_wr_o,
  output logic                     ii_val_wr_o,
  output logic [31:0]              variance_norm_factor_o,
  output logic                     cls_start_o,
  input  logic                     cls_done_i,
  input  logic                     cls_result_i,
  output logic [COORD_W-1:0]       win_x_o,
  output logic [COORD_W-1:0]       win_y_o,
  output logic                     det_val_o,
  input  logic                     det_ready_i,
  output logic [COORD_W-1:0]       det_x_o,
  output logic [COORD_W-1:0]       det_y_o,
  output logic [15:0]              det_cnt_o
);

  localparam int unsigned L     = LENGHT_LINE_II;
  localparam int unsigned RC_W  = (L > 1) ? $clog2(L) : 1;
  localparam logic        DEGEN = (IMG_W < L) || (IMG_H < L);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_VNF    = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;
  localparam logic [2:0] S_NEXT   = 3'd6;

  logic [2:0]               state_q, state_d;
  logic [COORD_W-1:0]       x0_q, x0_d, y0_q, y0_d;
  logic [RC_W-1:0]          r_q, r_d, c_q, c_d;
  logic                     drain_q, drain_d;
  logic                     wr_q, wr_d;
  logic [ADDR_WIDTH_II-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]              vnf_q, vnf_d;
  logic [15:0]              det_cnt_q, det_cnt_d;
  logic                     done_q, done_d;

  logic                     rd;
  logic [ADDR_WIDTH_FR-1:0] rd_addr;
  logic [ADDR_WIDTH_II-1:0] ii_addr;

  assign rd      = (state_q == S_LOAD) && !drain_q;
  assign rd_addr = ADDR_WIDTH_FR'((32'(y0_q) + 32'(r_q)) * IMG_W + 32'(x0_q) + 32'(c_q));
  assign ii_addr = ADDR_WIDTH_II'(32'(r_q) * L + 32'(c_q));

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    r_d       = r_q;
    c_d       = c_q;
    drain_d   = drain_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    vnf_d     = vnf_q;
    det_cnt_d = det_cnt_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
          x0_d      = '0;
          y0_d      = '0;
          det_cnt_d = '0;
          if (DEGEN) begin
            done_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            r_d     = '0;
            c_d     = '0;
            drain_d = 1'b0;
          end
        end
      end
      S_LOAD: begin
        if (drain_q) begin
          state_d = S_VNF;
        end else begin
          // write of this element lands one cycle later, alongside its read data
          wr_d      = 1'b1;
          wr_addr_d = ii_addr;
          if (c_q == RC_W'(L - 1)) begin
            c_d = '0;
            if (r_q == RC_W'(L - 1)) drain_d = 1'b1;
            else                     r_d     = r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      S_VNF: begin
        if (vnf_val_i) begin
          vnf_d   = vnf_i;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (cls_done_i) state_d = cls_result_i ? S_REPORT : S_NEXT;
      end
      S_REPORT: begin
        if (det_ready_i) begin
          if (det_cnt_q != '1) det_cnt_d = det_cnt_q + 16'd1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        state_d = S_LOAD;
        r_d     = '0;
        c_d     = '0;
        drain_d = 1'b0;
        if (32'(x0_q) + STEP + L <= IMG_W) begin
          x0_d = x0_q + COORD_W'(STEP);
        end else if (32'(y0_q) + STEP + L <= IMG_H) begin
          x0_d = '0;
          y0_d = y0_q + COORD_W'(STEP);
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      x0_d      = x0_q;
      y0_d      = y0_q;
      wr_d      = 1'b0;
      vnf_d     = vnf_q;
      det_cnt_d = det_cnt_q;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      r_q       <= '0;
      c_q       <= '0;
      drain_q   <= 1'b0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      vnf_q     <= '0;
      det_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      r_q       <= r_d;
      c_q       <= c_d;
      drain_q   <= drain_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      vnf_q     <= vnf_d;
      det_cnt_q <= det_cnt_d;
      done_q    <= done_d;
    end
  end

  assign busy_o                 = (state_q != S_IDLE);
  assign frame_done_o           = done_q;
  assign fr_rd_o                = rd;
  assign fr_addr_o              = rd ? rd_addr : '0;
  assign ii_val_wr_o            = wr_q;
  assign ii_addr_wr_o           = wr_addr_q;
  assign ii_data_wr_o           = wr_q ? fr_data_i : '0;
  assign variance_norm_factor_o = vnf_q;
  assign cls_start_o            = (state_q == S_START);
  assign win_x_o                = x0_q;
  assign win_y_o                = y0_q;
  assign det_val_o              = (state_q == S_REPORT);
  assign det_x_o                = x0_q;
  assign det_y_o                = y0_q;
  assign det_cnt_o              = det_cnt_q;

endmodule

// File: tb/tb_run_window_scan_scheduler.sv
// Directed bench for run_window_scan_scheduler: a 23x22 frame scanned with a
// 21-pixel window, plus a 20x22 instance for the too-small-frame case.
module tb_run_window_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        frame_start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        busy_o, frame_done_o, fr_rd_o;
  logic [8:0]  fr_addr_o;
  logic [31:0] fr_data_i = '0;
  logic        vnf_val_i = 1'b1;
  logic [31:0] vnf_i = 32'h0000_1234;
  logic [8:0]  ii_addr_wr_o;
  logic [31:0] ii_data_wr_o;
  logic        ii_val_wr_o;
  logic [31:0] variance_norm_factor_o;
  logic        cls_start_o;
  logic        cls_done_i = 1'b0;
  logic        cls_result_i = 1'b0;
  logic [15:0] win_x_o, win_y_o;
  logic        det_val_o;
  logic        det_ready_i = 1'b1;
  logic [15:0] det_x_o, det_y_o, det_cnt_o;

  logic        d_frame_start = 1'b0;
  logic        d_busy, d_frame_done, d_fr_rd, d_ii_val, d_cls_start, d_det_val;
  logic [8:0]  d_fr_addr, d_ii_addr;
  logic [31:0] d_ii_data, d_vnf_out;
  logic [15:0] d_win_x, d_win_y, d_det_x, d_det_y, d_det_cnt;

  int total = 0;
  int bad   = 0;

  run_window_scan_scheduler #(.LENGHT_LINE_II(21), .IMG_W(23), .IMG_H(22), .STEP(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .frame_start_i(frame_start_i), .abort_i(abort_i),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .fr_rd_o(fr_rd_o), .fr_addr_o(fr_addr_o),
    .fr_data_i(fr_data_i), .vnf_val_i(vnf_val_i), .vnf_i(vnf_i),
    .ii_addr_wr_o(ii_addr_wr_o), .ii_data_wr_o(ii_data_wr_o), .ii_val_wr_o(ii_val_wr_o),
    .variance_norm_factor_o(variance_norm_factor_o), .cls_start_o(cls_start_o),
    .cls_done_i(cls_done_i), .cls_result_i(cls_result_i),
    .win_x_o(win_x_o), .win_y_o(win_y_o), .det_val_o(det_val_o), .det_ready_i(det_ready_i),
    .det_x_o(det_x_o), .det_y_o(det_y_o), .det_cnt_o(det_cnt_o)
  );

  run_window_scan_scheduler #(.LENGHT_LINE_II(21), .IMG_W(20), .IMG_H(22), .STEP(1)) dut_d (
    .clk_i(clk), .rst_i(rst_i), .frame_start_i(d_frame_start), .abort_i(1'b0),
    .busy_o(d_busy), .frame_done_o(d_frame_done), .fr_rd_o(d_fr_rd), .fr_addr_o(d_fr_addr),
    .fr_data_i(32'd0), .vnf_val_i(1'b1), .vnf_i(32'd0),
    .ii_addr_wr_o(d_ii_addr), .ii_data_wr_o(d_ii_data), .ii_val_wr_o(d_ii_val),
    .variance_norm_factor_o(d_vnf_out), .cls_start_o(d_cls_start),
    .cls_done_i(1'b0), .cls_result_i(1'b0),
    .win_x_o(d_win_x), .win_y_o(d_win_y), .det_val_o(d_det_val), .det_ready_i(1'b1),
    .det_x_o(d_det_x), .det_y_o(d_det_y), .det_cnt_o(d_det_cnt)
  );

  always #5 clk = ~clk;

  // frame memory returns its own address, one cycle after the read strobe
  always @(posedge clk) if (fr_rd_o) fr_data_i <= 32'(fr_addr_o);

  int          n_start = 0;
  int          wr_cnt = 0;
  int          d_rd_cnt = 0;
  logic        mon_en = 1'b0;
  logic [31:0] cap [0:511];

  always @(negedge clk) begin
    if (cls_start_o) n_start <= n_start + 1;
    if (d_fr_rd) d_rd_cnt <= d_rd_cnt + 1;
    if (mon_en && ii_val_wr_o && win_x_o == 16'd2 && win_y_o == 16'd1) begin
      wr_cnt <= wr_cnt + 1;
      cap[ii_addr_wr_o] <= ii_data_wr_o;
    end
  end

  logic [5:0]   ctrl_outs;
  logic [167:0] all_outs;
  assign ctrl_outs = {busy_o, frame_done_o, fr_rd_o, ii_val_wr_o, cls_start_o, det_val_o};
  assign all_outs  = {ctrl_outs, fr_addr_o, ii_addr_wr_o, ii_data_wr_o, det_cnt_o,
                      variance_norm_factor_o, win_x_o, win_y_o, det_x_o, det_y_o};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1000000");
    $fatal(1);
  end

  task automatic start_frame();
    @(negedge clk); frame_start_i = 1'b1;
    @(negedge clk); frame_start_i = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cls_start_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic classify(input logic res);
    @(negedge clk); cls_done_i = 1'b1; cls_result_i = res;
    @(negedge clk); cls_done_i = 1'b0; cls_result_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (ctrl_outs !== 6'b0) begin bad++; $display("FAIL reset_ctrl: got %b expected 000000", ctrl_outs); end
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL reset_all: got %h expected 0", all_outs); end
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_scan_order();
    int ex [6] = '{0, 1, 2, 0, 1, 2};
    int ey [6] = '{0, 0, 0, 1, 1, 1};
    int n0;
    int bad_map;
    bit ok;
    n0 = n_start;
    mon_en = 1'b1;
    start_frame();
    for (int w = 0; w < 6; w++) begin
      wait_start(600, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL scan_start%0d: got timeout expected cls_start", w); end
      total++;
      if (win_x_o !== 16'(ex[w]) || win_y_o !== 16'(ey[w])) begin
        bad++; $display("FAIL scan_origin%0d: got (%0d,%0d) expected (%0d,%0d)", w, win_x_o, win_y_o, ex[w], ey[w]);
      end
      classify(1'b0);
    end
    wait_done(10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL scan_done: got timeout expected frame_done"); end
    total++;
    if (busy_o !== 1'b0 || det_cnt_o !== 16'd0) begin
      bad++; $display("FAIL scan_end_state: got busy=%b cnt=%0d expected busy=0 cnt=0", busy_o, det_cnt_o);
    end
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    total++;
    if (n_start - n0 != 6) begin bad++; $display("FAIL scan_pulses: got %0d expected 6", n_start - n0); end
    total++;
    if (wr_cnt != 441) begin bad++; $display("FAIL load_writes: got %0d expected 441", wr_cnt); end
    total++;
    if (cap[440] !== 32'd505) begin bad++; $display("FAIL load_last: got %0d expected 505", cap[440]); end
    bad_map = 0;
    for (int r = 0; r < 21; r++)
      for (int c = 0; c < 21; c++)
        if (cap[r*21+c] !== 32'((1 + r) * 23 + (2 + c))) bad_map++;
    total++;
    if (bad_map != 0) begin bad++; $display("FAIL load_map: got %0d wrong words expected 0", bad_map); end
  endtask

  task automatic test_backpressure();
    int hold;
    bit ok;
    det_ready_i = 1'b0;
    start_frame();
    wait_start(600, ok);
    classify(1'b0);
    wait_start(600, ok);
    total++;
    if (!ok || win_x_o !== 16'd1 || win_y_o !== 16'd0) begin
      bad++; $display("FAIL bp_origin: got ok=%0d (%0d,%0d) expected ok=1 (1,0)", ok, win_x_o, win_y_o);
    end
    classify(1'b1);
    hold = 0;
    for (int k = 0; k < 6; k++) begin
      if (det_val_o === 1'b1 && det_x_o === 16'd1 && det_y_o === 16'd0 && det_cnt_o === 16'd0) hold++;
      if (k == 5) det_ready_i = 1'b1;
      @(negedge clk);
    end
    total++;
    if (hold != 6) begin bad++; $display("FAIL bp_hold: got %0d stable cycles expected 6", hold); end
    total++;
    if (det_val_o !== 1'b0 || det_cnt_o !== 16'd1) begin
      bad++; $display("FAIL bp_handshake: got val=%b cnt=%0d expected val=0 cnt=1", det_val_o, det_cnt_o);
    end
    for (int w = 2; w < 6; w++) begin
      wait_start(600, ok);
      classify(1'b0);
    end
    wait_done(10, ok);
    total++;
    if (!ok || det_cnt_o !== 16'd1) begin
      bad++; $display("FAIL bp_final_cnt: got ok=%0d cnt=%0d expected ok=1 cnt=1", ok, det_cnt_o);
    end
  endtask

  task automatic test_vnf_stall();
    bit seen;
    bit ok;
    int stall_ok;
    vnf_val_i = 1'b0;
    start_frame();
    seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (fr_rd_o) seen = 1'b1;
      else if (seen) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL vnf_load_end: got timeout expected end of reads"); end
    @(negedge clk);
    stall_ok = 0;
    for (int k = 0; k < 10; k++) begin
      if (cls_start_o === 1'b0 && busy_o === 1'b1 && variance_norm_factor_o === 32'h0000_1234) stall_ok++;
      @(negedge clk);
    end
    total++;
    if (stall_ok != 10 || cls_start_o !== 1'b0) begin
      bad++; $display("FAIL vnf_stall: got %0d good cycles start=%b expected 10 start=0", stall_ok, cls_start_o);
    end
    vnf_val_i = 1'b1;
    vnf_i = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if (cls_start_o !== 1'b1 || variance_norm_factor_o !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL vnf_latch: got start=%b vnf=%h expected start=1 vnf=deadbeef", cls_start_o, variance_norm_factor_o);
    end
    vnf_i = 32'h5555_0000;
    @(negedge clk);
    total++;
    if (variance_norm_factor_o !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL vnf_hold: got %h expected deadbeef", variance_norm_factor_o);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    vnf_i = 32'h0000_1234;
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL vnf_abort: got busy=%b expected 0", busy_o); end
  endtask

  task automatic test_abort();
    bit ok;
    int done_seen;
    det_ready_i = 1'b1;
    @(negedge clk); frame_start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk); frame_start_i = 1'b0; abort_i = 1'b0;
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL abort_idle_start: got busy=%b expected 1", busy_o); end
    wait_start(600, ok);
    classify(1'b1);
    wait_start(600, ok);
    frame_start_i = 1'b1;
    @(negedge clk); frame_start_i = 1'b0; cls_done_i = 1'b1;
    @(negedge clk); cls_done_i = 1'b0;
    wait_start(600, ok);
    total++;
    if (!ok || win_x_o !== 16'd2 || win_y_o !== 16'd0) begin
      bad++; $display("FAIL abort_third_origin: got ok=%0d (%0d,%0d) expected ok=1 (2,0)", ok, win_x_o, win_y_o);
    end
    @(negedge clk); abort_i = 1'b1;
    @(negedge clk); abort_i = 1'b0;
    total++;
    if (busy_o !== 1'b0 || {fr_rd_o, ii_val_wr_o, cls_start_o, det_val_o} !== 4'b0) begin
      bad++; $display("FAIL abort_state: got busy=%b strobes=%b expected 0 0000", busy_o, {fr_rd_o, ii_val_wr_o, cls_start_o, det_val_o});
    end
    total++;
    if (det_cnt_o !== 16'd1) begin bad++; $display("FAIL abort_cnt: got %0d expected 1", det_cnt_o); end
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (frame_done_o !== 1'b0 || busy_o !== 1'b0) done_seen++;
      cls_done_i = (k == 3);
      cls_result_i = (k == 3);
      @(negedge clk);
    end
    total++;
    if (done_seen != 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles expected 0", done_seen); end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    start_frame();
    wait_start(600, ok);
    classify(1'b0);
    repeat (50) @(negedge clk);
    total++;
    if (fr_rd_o !== 1'b1 || win_x_o !== 16'd1) begin
      bad++; $display("FAIL rst_pre: got rd=%b x=%0d expected rd=1 x=1", fr_rd_o, win_x_o);
    end
    rst_i = 1'b0;
    #1;
    total++;
    if (ctrl_outs !== 6'b0) begin bad++; $display("FAIL rst_async_ctrl: got %b expected 000000", ctrl_outs); end
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL rst_async_all: got %h expected 0", all_outs); end
    @(negedge clk); rst_i = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy_o !== 1'b0 || fr_rd_o !== 1'b0) begin
      bad++; $display("FAIL rst_after: got busy=%b rd=%b expected 0 0", busy_o, fr_rd_o);
    end
  endtask

  task automatic test_degenerate();
    int rd0;
    rd0 = d_rd_cnt;
    @(negedge clk); d_frame_start = 1'b1;
    total++;
    if (d_frame_done !== 1'b0) begin bad++; $display("FAIL degen_pre: got %b expected 0", d_frame_done); end
    @(negedge clk); d_frame_start = 1'b0;
    total++;
    if (d_frame_done !== 1'b1 || d_busy !== 1'b0) begin
      bad++; $display("FAIL degen_done: got done=%b busy=%b expected 1 0", d_frame_done, d_busy);
    end
    repeat (3) @(negedge clk);
    total++;
    if (d_frame_done !== 1'b0 || d_busy !== 1'b0 || d_rd_cnt != rd0) begin
      bad++; $display("FAIL degen_after: got done=%b busy=%b reads=%0d expected 0 0 0", d_frame_done, d_busy, d_rd_cnt - rd0);
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_backpressure();
    test_vnf_stall();
    test_abort();
    test_reset_mid_load();
    test_degenerate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
